timekeeper_ctrl: RTL and testbench

Sequencing controller for the 7-segment time display path: owns the stopwatch count, the countdown timer and a small lap memory, all in {minutes[5:0], seconds[5:0]} format, and drives the `output_select` / `counter_out` / `timer_out` / `memory_out` inputs of the existing display decoder. It divides the 100 Hz board clock to a 1 Hz tick and interprets single-cycle button pulses supplied by upstream synchronizer/edge-detector logic. It is instantiated in `top` between the pushbutton conditioning and the decoder.

---
 rtl/timekeeper_pkg.sv | 21 ++
 rtl/mmss_counter.sv | 29 ++
 rtl/timekeeper_ctrl.sv | 112 +++++++++++
 tb/tb_timekeeper_ctrl.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/timekeeper_pkg.sv
// timekeeper_pkg: shared states, decoder selects and the {min, sec} time format
package timekeeper_pkg;
    localparam logic [2:0] ST_SW_IDLE  = 3'd0;
    localparam logic [2:0] ST_SW_RUN   = 3'd1;
    localparam logic [2:0] ST_TM_IDLE  = 3'd2;
    localparam logic [2:0] ST_TM_RUN   = 3'd3;
    localparam logic [2:0] ST_TM_ALARM = 3'd4;
    localparam logic [2:0] ST_RECALL   = 3'd5;
    localparam logic [2:0] SEL_COUNTER = 3'd0;
    localparam logic [2:0] SEL_TIMER   = 3'd1;
    localparam logic [2:0] SEL_MEMORY  = 3'd2;
    localparam logic [5:0] MMSS_MAX_SEC = 6'd59;
    localparam logic [5:0] MMSS_MAX_MIN = 6'd59;
    typedef struct packed {
        logic [5:0] min;
        logic [5:0] sec;
    } mmss_t;
    function automatic logic mmss_valid(input mmss_t v);
        return v.min <= MMSS_MAX_MIN && v.sec <= MMSS_MAX_SEC;
    endfunction
endpackage

// File: rtl/mmss_counter.sv
// mmss_counter: {min, sec} up/down counter with 59 wrap, sync clear and load
module mmss_counter import timekeeper_pkg::*; (
    input  logic  hz100,
    input  logic  n_rst,
    input  logic  en,
    input  logic  up,
    input  logic  clr,
    input  logic  ld,
    input  mmss_t ld_value,
    output mmss_t value
);
    mmss_t nxt;
    logic sec_wrap;
    always_comb begin
        nxt = value;
        sec_wrap = up ? value.sec == MMSS_MAX_SEC : value.sec == 6'd0;
        nxt.sec = up ? (sec_wrap ? 6'd0 : value.sec + 6'd1)
                     : (sec_wrap ? MMSS_MAX_SEC : value.sec - 6'd1);
        nxt.min = !sec_wrap ? value.min
                : up ? (value.min == MMSS_MAX_MIN ? 6'd0 : value.min + 6'd1)
                     : (value.min == 6'd0 ? MMSS_MAX_MIN : value.min - 6'd1);
    end
    always_ff @(posedge hz100 or negedge n_rst) begin
        if (!n_rst) value <= '0;
        else if (clr) value <= '0;
        else if (ld) value <= ld_value;
        else if (en) value <= nxt;
    end
endmodule

// File: rtl/timekeeper_ctrl.sv
// timekeeper_ctrl: stopwatch / countdown / lap-recall sequencer feeding the 7-segment decoder
module timekeeper_ctrl import timekeeper_pkg::*; #(
    parameter int TICKS_PER_SEC = 100,
    parameter int LAP_DEPTH     = 4
) (
    input  logic        hz100,
    input  logic        n_rst,
    input  logic        start_stop,
    input  logic        lap,
    input  logic        mode,
    input  logic        clear,
    input  logic        load,
    input  logic [11:0] load_value,
    output logic [2:0]  output_select,
    output logic [11:0] counter_out,
    output logic [11:0] timer_out,
    output logic [11:0] memory_out,
    output logic        running,
    output logic        alarm
);
    localparam int PW = TICKS_PER_SEC > 1 ? $clog2(TICKS_PER_SEC) : 1;
    localparam int AW = $clog2(LAP_DEPTH);
    localparam int CW = $clog2(LAP_DEPTH + 1);
    logic [2:0] state, nxt;
    logic [PW-1:0] pre;
    logic [AW-1:0] wp, rp;
    logic [CW-1:0] lap_count;
    logic [11:0] mem [LAP_DEPTH];
    mmss_t sw_value, tm_value;
    logic do_clr, do_ss, do_ld, do_md, do_lap, any_pulse;
    logic run_st, nxt_run, tick, sw_clr, tm_clr, tm_ld, tm_last;
    // Only the highest-priority pulse of a cycle is considered; the rest are dropped
    assign do_clr    = clear;
    assign do_ss     = start_stop & ~clear;
    assign do_ld     = load & ~clear & ~start_stop;
    assign do_md     = mode & ~(clear | start_stop | load);
    assign do_lap    = lap & ~(clear | start_stop | load | mode);
    assign any_pulse = clear | start_stop | load | mode | lap;
    assign run_st  = state == ST_SW_RUN || state == ST_TM_RUN;
    assign nxt_run = nxt == ST_SW_RUN || nxt == ST_TM_RUN;
    assign tick    = run_st && pre == PW'(TICKS_PER_SEC - 1);
    assign sw_clr  = do_clr && state == ST_SW_IDLE;
    assign tm_clr  = do_clr && state == ST_TM_IDLE;
    assign tm_ld   = do_ld && state == ST_TM_IDLE && mmss_valid(load_value);
    assign tm_last = tm_value == mmss_t'(12'd1);
    always_comb begin
        nxt = state;
        case (state)
            ST_SW_IDLE:  nxt = do_ss ? ST_SW_RUN : do_md ? ST_TM_IDLE : state;
            ST_SW_RUN:   nxt = do_ss ? ST_SW_IDLE : state;
            ST_TM_IDLE:  nxt = (do_ss && tm_value != '0) ? ST_TM_RUN : do_md ? ST_RECALL : state;
            ST_TM_RUN:   nxt = (tick && tm_last) ? ST_TM_ALARM : do_ss ? ST_TM_IDLE : state;
            ST_TM_ALARM: nxt = any_pulse ? ST_TM_IDLE : state;
            ST_RECALL:   nxt = do_md ? ST_SW_IDLE : state;
            default:     nxt = ST_SW_IDLE;
        endcase
    end
    always_ff @(posedge hz100 or negedge n_rst) begin
        if (!n_rst) state <= ST_SW_IDLE;
        else state <= nxt;
    end
    // A fresh run always starts a full second; a pause simply freezes the count
    always_ff @(posedge hz100 or negedge n_rst) begin
        if (!n_rst) pre <= '0;
        else if ((nxt_run && !run_st) || sw_clr || tm_clr) pre <= '0;
        else if (run_st) pre <= tick ? '0 : pre + 1'b1;
    end
    mmss_counter u_sw (
        .hz100    (hz100),
        .n_rst    (n_rst),
        .en       (tick && state == ST_SW_RUN),
        .up       (1'b1),
        .clr      (sw_clr),
        .ld       (1'b0),
        .ld_value ('0),
        .value    (sw_value)
    );
    mmss_counter u_tm (
        .hz100    (hz100),
        .n_rst    (n_rst),
        .en       (tick && state == ST_TM_RUN),
        .up       (1'b0),
        .clr      (tm_clr),
        .ld       (tm_ld),
        .ld_value (mmss_t'(load_value)),
        .value    (tm_value)
    );
    always_ff @(posedge hz100 or negedge n_rst) begin
        if (!n_rst || sw_clr) begin
            wp <= '0;
            rp <= '0;
            lap_count <= '0;
            for (int i = 0; i < LAP_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_lap && state == ST_SW_RUN) begin
                mem[wp] <= sw_value;
                wp <= wp + 1'b1;
                lap_count <= lap_count == CW'(LAP_DEPTH) ? lap_count : lap_count + 1'b1;
            end
            if (do_md && state == ST_TM_IDLE) rp <= wp - 1'b1;
            else if (do_lap && state == ST_RECALL && lap_count != '0)
                rp <= rp == '0 ? AW'(lap_count - 1'b1) : rp - 1'b1;
        end
    end
    assign counter_out   = sw_value;
    assign timer_out     = tm_value;
    assign memory_out    = lap_count == '0 ? 12'd0 : mem[rp];
    assign running       = run_st;
    assign alarm         = state == ST_TM_ALARM;
    assign output_select = state == ST_RECALL ? SEL_MEMORY
                         : (state == ST_SW_IDLE || state == ST_SW_RUN) ? SEL_COUNTER : SEL_TIMER;
endmodule

// File: tb/tb_timekeeper_ctrl.sv
// tb_timekeeper_ctrl: directed checks of stopwatch, timer, lap recall and reset behaviour
module tb_timekeeper_ctrl;
    localparam int T = 10;
    localparam logic [4:0] P_CLR = 5'b10000, P_SS = 5'b01000, P_LD = 5'b00100,
                           P_MD = 5'b00010, P_LAP = 5'b00001;
    logic hz100 = 1'b0, n_rst = 1'b0;
    logic start_stop = 1'b0, lap = 1'b0, mode = 1'b0, clear = 1'b0, load = 1'b0;
    logic [11:0] load_value = '0;
    logic [2:0] output_select;
    logic [11:0] counter_out, timer_out, memory_out;
    logic running, alarm;
    int total = 0, bad = 0;
    timekeeper_ctrl #(.TICKS_PER_SEC(T), .LAP_DEPTH(4)) dut (
        .hz100         (hz100),
        .n_rst         (n_rst),
        .start_stop    (start_stop),
        .lap           (lap),
        .mode          (mode),
        .clear         (clear),
        .load          (load),
        .load_value    (load_value),
        .output_select (output_select),
        .counter_out   (counter_out),
        .timer_out     (timer_out),
        .memory_out    (memory_out),
        .running       (running),
        .alarm         (alarm)
    );
    always #5 hz100 = ~hz100;
    task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    task automatic wait_cyc(input int n);
        repeat (n) @(negedge hz100);
    endtask
    task automatic pulse(input logic [4:0] p);
        {clear, start_stop, load, mode, lap} = p;
        @(negedge hz100);
        {clear, start_stop, load, mode, lap} = '0;
    endtask
    initial begin
        wait_cyc(2);
        check("rst_sel", 12'(output_select), 12'd0);
        check("rst_cnt", counter_out, 12'd0);
        check("rst_tmr", timer_out, 12'd0);
        check("rst_mem", memory_out, 12'd0);
        check("rst_run", 12'(running), 12'd0);
        check("rst_alm", 12'(alarm), 12'd0);
        n_rst = 1'b1;
        wait_cyc(1);
        pulse(P_SS);
        wait_cyc(T - 1);
        check("first_tick_early", counter_out, 12'd0);
        wait_cyc(1);
        check("first_tick", counter_out, 12'd1);
        wait_cyc(60 * T);
        check("sw_61s", counter_out, 12'h041);
        check("sw_61s_run", 12'(running), 12'd1);
        check("sw_61s_sel", 12'(output_select), 12'd0);
        wait_cyc(3538 * T);
        check("sw_5959", counter_out, 12'hEFB);
        wait_cyc(T);
        check("sw_wrap", counter_out, 12'd0);
        check("sw_wrap_run", 12'(running), 12'd1);
        pulse(P_SS);
        pulse(P_SS);
        wait_cyc(3 * T);
        pulse(P_SS);
        check("sw_3s_paused", counter_out, 12'd3);
        check("sw_paused_run", 12'(running), 12'd0);
        pulse(P_CLR | P_SS);
        check("clr_ss_cnt", counter_out, 12'd0);
        check("clr_ss_run", 12'(running), 12'd0);
        wait_cyc(2 * T);
        check("clr_ss_hold", counter_out, 12'd0);
        pulse(P_SS);
        for (int i = 1; i <= 5; i++) begin
            wait_cyc(i == 1 ? T : T - 1);
            pulse(P_LAP);
        end
        pulse(P_SS);
        check("lap_cnt5", counter_out, 12'd5);
        pulse(P_MD);
        pulse(P_MD);
        check("rec_sel", 12'(output_select), 12'd2);
        check("rec_newest", memory_out, 12'd5);
        pulse(P_LAP);
        check("rec_4", memory_out, 12'd4);
        pulse(P_LAP);
        check("rec_3", memory_out, 12'd3);
        pulse(P_LAP);
        check("rec_2", memory_out, 12'd2);
        pulse(P_LAP);
        check("rec_wrap", memory_out, 12'd5);
        pulse(P_MD);
        check("rec_exit_sel", 12'(output_select), 12'd0);
        pulse(P_MD);
        check("tm_sel", 12'(output_select), 12'd1);
        pulse(P_SS);
        check("tm_start_zero", 12'(running), 12'd0);
        load_value = 12'h03C;
        pulse(P_LD);
        check("tm_load_bad", timer_out, 12'd0);
        load_value = 12'h002;
        pulse(P_LD);
        check("tm_load", timer_out, 12'd2);
        pulse(P_SS);
        check("tm_run", 12'(running), 12'd1);
        wait_cyc(T);
        check("tm_1s", timer_out, 12'd1);
        check("tm_1s_alm", 12'(alarm), 12'd0);
        wait_cyc(T);
        check("tm_zero", timer_out, 12'd0);
        check("tm_alarm", 12'(alarm), 12'd1);
        check("tm_alarm_run", 12'(running), 12'd0);
        check("tm_alarm_sel", 12'(output_select), 12'd1);
        pulse(P_LAP);
        check("alm_clr", 12'(alarm), 12'd0);
        check("alm_clr_sel", 12'(output_select), 12'd1);
        check("alm_clr_run", 12'(running), 12'd0);
        load_value = 12'h040;
        pulse(P_LD);
        pulse(P_SS);
        wait_cyc(T + 3);
        check("tm_borrow", timer_out, 12'h03B);
        n_rst = 1'b0;
        #1;
        check("arst_sel", 12'(output_select), 12'd0);
        check("arst_tmr", timer_out, 12'd0);
        check("arst_cnt", counter_out, 12'd0);
        check("arst_mem", memory_out, 12'd0);
        check("arst_run", 12'(running), 12'd0);
        wait_cyc(2);
        n_rst = 1'b1;
        wait_cyc(1);
        pulse(P_MD);
        check("post_rst_sel", 12'(output_select), 12'd1);
        pulse(P_SS);
        check("post_rst_start0", 12'(running), 12'd0);
        wait_cyc(2 * T);
        check("post_rst_tmr", timer_out, 12'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
